// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and parity mode constants for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    DATA  = 3'b011,
    PAR   = 3'b111,
    STOP  = 3'b010
  } state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider, pulses bit_end in the last cycle of each period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic Bclk,
  input  logic reset_n,
  input  logic clr,
  output logic bit_end
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == LAST;
  // count up, wrapping at the period end; clear restarts phase at frame acceptance
  always_comb cnt_d = (clr || bit_end) ? '0 : cnt_q + 1'b1;
  // divider register
  always_ff @(posedge Bclk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready capture and bit-period divider
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              Bclk,
  input  logic              reset_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_din,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_data
);
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
  end
  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_data_q, tx_data_d;
  logic              accept, bit_end, done;
  assign accept   = tx_valid && state_q == IDLE;
  assign tx_busy  = state_q != IDLE;
  assign tx_ready = ~tx_busy;
  assign tx_done  = done;
  assign tx_data  = tx_data_q;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .Bclk    (Bclk),
    .reset_n (reset_n),
    .clr     (accept),
    .bit_end (bit_end)
  );
  // next state: each bit period end presents the following frame bit on the registered line
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_data_d = tx_data_q;
    done      = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        shift_d   = tx_din;
        par_d     = (^tx_din) ^ (PARITY == PARITY_ODD);
        tx_data_d = 1'b0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: if (bit_end) begin
        tx_data_d = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_end) begin
        if (bit_cnt_q == 4'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          state_d   = PARITY != PARITY_NONE ? PAR : STOP;
          tx_data_d = PARITY != PARITY_NONE ? par_q : 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          tx_data_d = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      PAR: if (bit_end) begin
        bit_cnt_d = '0;
        tx_data_d = 1'b1;
        state_d   = STOP;
      end
      STOP: if (bit_end) begin
        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
          bit_cnt_d = '0;
          done      = 1'b1;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_data_d = 1'b1;
        bit_cnt_d = '0;
      end
    endcase
  end
  // state, counter, shift and line registers
  always_ff @(posedge Bclk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_data_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_data_q <= tx_data_d;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four parameter variants driven from vector tables, hand sequences and random frames
module tb_uart_tx_param;
  localparam int DW  [4] = '{8, 8, 8, 5};
  localparam int PAR [4] = '{0, 1, 2, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};
  localparam int CPB [4] = '{4, 3, 2, 1};
  logic       Bclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] din = '0;
  logic [3:0] valid = '0;
  logic [3:0] data, busy, ready, done;
  int n_chk = 0;
  int n_pass = 0;
  always #5 Bclk = ~Bclk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_param #(
      .DATA_W(DW[g]), .PARITY(PAR[g]), .STOP_BITS(SB[g]), .CLKS_PER_BIT(CPB[g])
    ) u_dut (
      .Bclk     (Bclk),
      .reset_n  (reset_n),
      .tx_valid (valid[g]),
      .tx_din   (din[DW[g]-1:0]),
      .tx_ready (ready[g]),
      .tx_busy  (busy[g]),
      .tx_done  (done[g]),
      .tx_data  (data[g])
    );
  end
  typedef struct {
    int          k;
    logic [8:0]  din;
    logic [15:0] line;
    int          n;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask
  function automatic int frame_n(input int k);
    return 1 + DW[k] + (PAR[k] != 0 ? 1 : 0) + SB[k];
  endfunction
  function automatic logic [15:0] model(input int k, input logic [8:0] v);
    logic [15:0] f = '1;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < DW[k]; i++) begin
      f[1+i] = v[i];
      ones += int'(v[i]);
    end
    if (PAR[k] != 0) f[1+DW[k]] = (ones % 2 == 1) ^ (PAR[k] == 2);
    return f;
  endfunction
  task automatic send(input int k, input logic [8:0] v, input logic [15:0] line, input int n, input bit keep);
    int w = 0;
    int c = CPB[k];
    while (!ready[k] && w < 200) begin
      @(negedge Bclk);
      w++;
    end
    chk("wait_ready", ready[k], 1);
    din = v;
    valid[k] = 1'b1;
    @(posedge Bclk);
    #1;
    valid[k] = keep;
    din = 9'($urandom);
    for (int i = 0; i < n * c; i++) begin
      @(negedge Bclk);
      chk($sformatf("line%0d_bit%0d", k, i / c), data[k], line[i/c]);
      chk("busy_in_frame", busy[k], 1);
      chk("done_pulse", done[k], i == n * c - 1);
      valid[k] = keep | (i == 3 * c);
      if (i > 0) din = 9'($urandom);
    end
    @(negedge Bclk);
    chk("ready_after_done", ready[k], 1);
    chk("busy_after_done", busy[k], 0);
    chk("idle_line", data[k], 1);
    if (!keep) begin
      repeat (2) @(negedge Bclk);
      chk("no_extra_frame", busy[k], 0);
    end
  endtask
  initial begin
    tbl[0] = '{0, 9'h0A5, 16'hFC00 | {6'b0, 1'b1, 8'hA5, 1'b0}, 10};
    tbl[1] = '{1, 9'h003, 16'hF000 | {4'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11};
    tbl[2] = '{2, 9'h003, 16'hF000 | {4'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11};
    tbl[3] = '{3, 9'h01F, 16'hFF00 | {8'b0, 2'b11, 5'h1F, 1'b0}, 8};
    tbl[4] = '{1, 9'h007, 16'hF000 | {4'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};
    tbl[5] = '{2, 9'h000, 16'hF000 | {4'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11};
    tbl[6] = '{0, 9'h000, 16'hFC00 | {6'b0, 1'b1, 8'h00, 1'b0}, 10};
    tbl[7] = '{3, 9'h00A, 16'hFF00 | {8'b0, 2'b11, 5'h0A, 1'b0}, 8};
    repeat (2) @(negedge Bclk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_data", data[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_ready", ready[k], 1);
      chk("rst_done", done[k], 0);
    end
    reset_n = 1'b1;
    @(negedge Bclk);
    for (int t = 0; t < 8; t++) send(tbl[t].k, tbl[t].din, tbl[t].line, tbl[t].n, 1'b0);
    send(0, 9'h055, 16'hFC00 | {6'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b1);
    send(0, 9'h0AA, 16'hFC00 | {6'b0, 1'b1, 8'hAA, 1'b0}, 10, 1'b0);
    din = 9'h052;
    valid[0] = 1'b1;
    @(posedge Bclk);
    #1;
    valid[0] = 1'b0;
    repeat (4 * CPB[0] + 2) @(negedge Bclk);
    chk("pre_reset_bit3", data[0], 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_data", data[0], 1);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_ready", ready[0], 1);
    chk("async_rst_done", done[0], 0);
    @(negedge Bclk);
    chk("rst_held_done", done[0], 0);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge Bclk);
      chk("post_rst_done", done[0], 0);
      chk("post_rst_busy", busy[0], 0);
    end
    send(0, 9'h0C3, model(0, 9'h0C3), frame_n(0), 1'b0);
    begin
      int pk = 0;
      bit keep = 1'b0;
      for (int it = 0; it < 30; it++) begin
        int k = keep ? pk : int'($urandom_range(0, 3));
        logic [8:0] v = 9'($urandom);
        keep = (it < 29) && ($urandom_range(0, 3) == 0);
        pk = k;
        send(k, v, model(k, v), frame_n(k), keep);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
